cc_cond_unit: RTL and testbench

- Consumer end of the ALU condition-flag interface: latches the 3-bit flag vector {OF,SF,ZF} produced by the 64-bit ALU ops (add/sub/and/xor) into the architectural condition-code register (CC).
- Evaluates the jXX/cmovXX condition from CC.
- Sits in the Execute stage of the pipelined Y86-64 core; drives e_cnd to the branch-resolution logic and a registered M_cnd to the Memory stage.

---
 rtl/cc_cond_unit_pkg.sv | 28 ++
 rtl/cc_cond_unit_cond_eval.sv | 33 +++
 rtl/cc_cond_unit.sv | 90 +++++++++
 tb/tb_cc_cond_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_cond_unit_pkg.sv
// Shared Y86-64 condition-code definitions: icodes, condition ifuns, flag bit positions.
// Used by the condition unit and by decode (cmov write suppression).
package cc_cond_unit_pkg;

  localparam int CC_W  = 3;
  localparam int CF_ZF = 0;
  localparam int CF_SF = 1;
  localparam int CF_OF = 2;

  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  function automatic logic is_cond_icode(input logic [3:0] icode);
    return (icode == I_RRMOVQ) || (icode == I_JXX);
  endfunction

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Purely combinational jXX/cmovXX condition evaluator: (cc, ifun) -> (cnd, err).
// Out-of-range ifun yields cnd=0 and err=1.
module cc_cond_unit_cond_eval
  import cc_cond_unit_pkg::*;
(
  input  logic [CC_W-1:0] cc,
  input  logic [3:0]      ifun,
  output logic            cnd,
  output logic            err
);

  logic zf;
  logic lt;

  assign zf  = cc[CF_ZF];
  assign lt  = cc[CF_SF] ^ cc[CF_OF];
  assign err = (ifun > C_G);

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code register, condition evaluation and M-stage condition register.
// Optional jXX taken/not-taken statistics counters are enabled by defining CC_COND_STATS_EN.
module cc_cond_unit
  import cc_cond_unit_pkg::*;
#(
  parameter logic [CC_W-1:0] CC_RST = 3'b001,
  parameter int              CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            e_valid,
  input  logic [3:0]      e_icode,
  input  logic [3:0]      e_ifun,
  input  logic [CC_W-1:0] alu_cf,
  input  logic            exc_pending,
  input  logic            e_stall,
  input  logic            m_bubble,
  output logic [CC_W-1:0] cc,
`ifdef CC_COND_STATS_EN
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt,
`endif
  output logic            e_cnd,
  output logic            e_cond_err,
  output logic            M_cnd,
  output logic            M_valid
);

  logic raw_cnd;
  logic raw_err;
  logic cond_use;
  logic cc_we;

  cc_cond_unit_cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (e_ifun),
    .cnd  (raw_cnd),
    .err  (raw_err)
  );

  assign cond_use   = e_valid && is_cond_icode(e_icode);
  assign e_cnd      = cond_use && raw_cnd;
  assign e_cond_err = cond_use && raw_err;

  // An excepting older instruction freezes CC so the faulting state stays architecturally visible.
  assign cc_we = e_valid && (e_icode == I_OPQ) && !exc_pending && !e_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RST;
    end else if (cc_we) begin
      cc <= alu_cf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_cnd   <= 1'b0;
      M_valid <= 1'b0;
    end else if (!e_stall) begin
      if (m_bubble) begin
        M_cnd   <= 1'b0;
        M_valid <= 1'b0;
      end else begin
        M_cnd   <= e_cnd;
        M_valid <= e_valid;
      end
    end
  end

`ifdef CC_COND_STATS_EN
  logic jxx_retire;

  assign jxx_retire = e_valid && (e_icode == I_JXX) && !e_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (jxx_retire) begin
      if (e_cnd) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      end else begin
        if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// Self-checking bench for cc_cond_unit: directed scenarios plus randomized traffic vs a behavioural model.
// Statistics checks are compiled only when CC_COND_STATS_EN is defined.
module tb_cc_cond_unit;

  localparam int TB_CNT_W = 4;
  localparam logic [2:0] RST_CC = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_valid;
  logic [3:0] e_icode;
  logic [3:0] e_ifun;
  logic [2:0] alu_cf;
  logic       exc_pending;
  logic       e_stall;
  logic       m_bubble;
  logic [2:0] cc;
  logic       e_cnd;
  logic       e_cond_err;
  logic       M_cnd;
  logic       M_valid;
`ifdef CC_COND_STATS_EN
  logic [TB_CNT_W-1:0] taken_cnt;
  logic [TB_CNT_W-1:0] not_taken_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // behavioural model state
  logic [2:0] m_cc;
  logic       m_mcnd;
  logic       m_mvalid;
  int         m_taken;
  int         m_ntaken;

  always #5 clk = ~clk;

  cc_cond_unit #(.CC_RST(RST_CC), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .e_valid     (e_valid),
    .e_icode     (e_icode),
    .e_ifun      (e_ifun),
    .alu_cf      (alu_cf),
    .exc_pending (exc_pending),
    .e_stall     (e_stall),
    .m_bubble    (m_bubble),
    .cc          (cc),
`ifdef CC_COND_STATS_EN
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt),
`endif
    .e_cnd       (e_cnd),
    .e_cond_err  (e_cond_err),
    .M_cnd       (M_cnd),
    .M_valid     (M_valid)
  );

  // Condition semantics stated as flag predicates: "less" means the signed result was negative
  // after accounting for overflow, i.e. SF differs from OF.
  function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
    bit zf, less;
    zf   = c[0];
    less = (c[1] != c[2]);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_uses_cond(input logic v, input logic [3:0] ic);
    return v && (ic == 4'd2 || ic == 4'd7);
  endfunction

  function automatic logic ref_e_cnd();
    return ref_uses_cond(e_valid, e_icode) && (e_ifun <= 4'd6) && ref_cond(m_cc, e_ifun);
  endfunction

  function automatic logic ref_e_err();
    return ref_uses_cond(e_valid, e_icode) && (e_ifun > 4'd6);
  endfunction

  task automatic model_reset();
    m_cc     = RST_CC;
    m_mcnd   = 1'b0;
    m_mvalid = 1'b0;
    m_taken  = 0;
    m_ntaken = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] f,
                       input logic [2:0] cf, input logic exc, input logic st, input logic bub);
    e_valid     = v;
    e_icode     = ic;
    e_ifun      = f;
    alu_cf      = cf;
    exc_pending = exc;
    e_stall     = st;
    m_bubble    = bub;
    #1;
  endtask

  // Advance one clock edge, moving the model forward with the same inputs the DUT sees.
  task automatic tick(input string tag);
    logic [2:0] n_cc;
    logic       n_mcnd, n_mvalid, cnd_now;
    int         max_cnt;
    max_cnt  = (1 << TB_CNT_W) - 1;
    cnd_now  = ref_e_cnd();
    n_cc     = m_cc;
    n_mcnd   = m_mcnd;
    n_mvalid = m_mvalid;
    if (e_valid && e_icode == 4'd6 && !exc_pending && !e_stall) n_cc = alu_cf;
    if (!e_stall) begin
      n_mcnd   = m_bubble ? 1'b0 : cnd_now;
      n_mvalid = m_bubble ? 1'b0 : e_valid;
      if (e_valid && e_icode == 4'd7) begin
        if (cnd_now) m_taken  = (m_taken  < max_cnt) ? m_taken + 1  : m_taken;
        else         m_ntaken = (m_ntaken < max_cnt) ? m_ntaken + 1 : m_ntaken;
      end
    end
    @(posedge clk);
    m_cc     = n_cc;
    m_mcnd   = n_mcnd;
    m_mvalid = n_mvalid;
    #1;
    $display("[%s] t=%0t v=%0b ic=%0d if=%0d cf=%b exc=%0b st=%0b bub=%0b -> cc=%b M_cnd=%0b M_valid=%0b",
             tag, $time, e_valid, e_icode, e_ifun, alu_cf, exc_pending, e_stall, m_bubble,
             cc, M_cnd, M_valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    model_reset();
    #11;
    n_total++; if (cc !== 3'b001) $display("FAIL reset_cc got=%b exp=%b", cc, 3'b001); else n_pass++;
    n_total++; if (M_cnd !== 1'b0) $display("FAIL reset_M_cnd got=%b exp=0", M_cnd); else n_pass++;
    n_total++; if (M_valid !== 1'b0) $display("FAIL reset_M_valid got=%b exp=0", M_valid); else n_pass++;
`ifdef CC_COND_STATS_EN
    n_total++; if (taken_cnt !== '0 || not_taken_cnt !== '0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", taken_cnt, not_taken_cnt); else n_pass++;
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 4'd7, 4'd3, 3'b000, 1'b0, 1'b0, 1'b0);
    n_total++; if (e_cnd !== 1'b1) $display("FAIL first_je got=%b exp=1", e_cnd); else n_pass++;
    tick("reset_je");
    n_total++; if (M_cnd !== 1'b1 || M_valid !== 1'b1)
      $display("FAIL first_je_M got=%b%b exp=11", M_cnd, M_valid); else n_pass++;
  endtask

  task automatic test_opq_flags();
    drive(1'b1, 4'd6, 4'd0, 3'b010, 1'b0, 1'b0, 1'b0);
    n_total++; if (e_cnd !== 1'b0) $display("FAIL opq_no_cnd got=%b exp=0", e_cnd); else n_pass++;
    tick("opq_sf");
    n_total++; if (cc !== 3'b010) $display("FAIL opq_cc got=%b exp=010", cc); else n_pass++;
    drive(1'b1, 4'd7, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0);
    n_total++; if (e_cnd !== 1'b1) $display("FAIL jl_cnd got=%b exp=1", e_cnd); else n_pass++;
    tick("jl");
    n_total++; if (M_cnd !== 1'b1) $display("FAIL jl_M_cnd got=%b exp=1", M_cnd); else n_pass++;
    drive(1'b1, 4'd7, 4'd5, 3'b000, 1'b0, 1'b0, 1'b0);
    n_total++; if (e_cnd !== 1'b0) $display("FAIL jge_cnd got=%b exp=0", e_cnd); else n_pass++;
    tick("jge");
    n_total++; if (M_cnd !== 1'b0 || M_valid !== 1'b1)
      $display("FAIL jge_M got=%b%b exp=01", M_cnd, M_valid); else n_pass++;
  endtask

  task automatic test_exc_stall();
    drive(1'b1, 4'd6, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("opq_zf");
    drive(1'b1, 4'd6, 4'd0, 3'b100, 1'b1, 1'b0, 1'b0);
    tick("opq_exc");
    n_total++; if (cc !== 3'b001) $display("FAIL exc_blocks_cc got=%b exp=001", cc); else n_pass++;
    drive(1'b1, 4'd6, 4'd0, 3'b100, 1'b0, 1'b1, 1'b0);
    tick("opq_stall");
    n_total++; if (cc !== 3'b001) $display("FAIL stall_blocks_cc got=%b exp=001", cc); else n_pass++;
    drive(1'b1, 4'd6, 4'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    tick("opq_of");
    drive(1'b1, 4'd6, 4'd0, 3'b110, 1'b0, 1'b0, 1'b0);
    tick("opq_b2b");
    n_total++; if (cc !== 3'b110) $display("FAIL back_to_back_cc got=%b exp=110", cc); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [3:0] icodes [3];
    icodes[0] = 4'd2; icodes[1] = 4'd7; icodes[2] = 4'd6;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 4'd6, 4'd0, 3'(c), 1'b0, 1'b0, 1'b0);
      tick("sweep_set");
      n_total++; if (cc !== 3'(c)) $display("FAIL sweep_cc got=%b exp=%b", cc, 3'(c)); else n_pass++;
      for (int k = 0; k < 3; k++) begin
        for (int f = 0; f < 8; f++) begin
          drive(1'b1, icodes[k], 4'(f), 3'(c), 1'b0, 1'b0, 1'b0);
          n_total++; if (e_cnd !== ref_e_cnd())
            $display("FAIL sweep_cnd cc=%b ic=%0d if=%0d got=%b exp=%b", c[2:0], icodes[k], f, e_cnd, ref_e_cnd());
          else n_pass++;
          n_total++; if (e_cond_err !== ref_e_err())
            $display("FAIL sweep_err cc=%b ic=%0d if=%0d got=%b exp=%b", c[2:0], icodes[k], f, e_cond_err, ref_e_err());
          else n_pass++;
          tick("sweep");
        end
      end
      drive(1'b0, 4'd7, 4'd0, 3'(c), 1'b0, 1'b0, 1'b0);
      n_total++; if (e_cnd !== 1'b0) $display("FAIL bubble_cnd got=%b exp=0", e_cnd); else n_pass++;
    end
  endtask

  task automatic test_stall_bubble();
    drive(1'b1, 4'd6, 4'd0, 3'b110, 1'b0, 1'b0, 1'b0);
    tick("sb_opq");
    drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("sb_jmp");
    n_total++; if (M_cnd !== 1'b1 || M_valid !== 1'b1)
      $display("FAIL sb_load got=%b%b exp=11", M_cnd, M_valid); else n_pass++;
    drive(1'b0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b1, 1'b1);
    tick("sb_stall_bub");
    n_total++; if (M_cnd !== 1'b1 || M_valid !== 1'b1)
      $display("FAIL stall_over_bubble got=%b%b exp=11", M_cnd, M_valid); else n_pass++;
    drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    tick("sb_bubble");
    n_total++; if (M_cnd !== 1'b0 || M_valid !== 1'b0)
      $display("FAIL bubble got=%b%b exp=00", M_cnd, M_valid); else n_pass++;
    drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("sb_reload");
    drive(1'b1, 4'd6, 4'd0, 3'b011, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (cc !== 3'b001 || M_cnd !== 1'b0 || M_valid !== 1'b0)
      $display("FAIL midstream_reset got cc=%b M=%b%b exp cc=001 M=00", cc, M_cnd, M_valid); else n_pass++;
    drive(1'b0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick("sb_after_reset");
    n_total++; if (cc !== 3'b001) $display("FAIL post_reset_cc got=%b exp=001", cc); else n_pass++;
  endtask

`ifdef CC_COND_STATS_EN
  task automatic test_stats();
    drive(1'b1, 4'd6, 4'd0, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("st_opq");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd7, 4'd0, 3'b000, (i == 1), 1'b0, 1'b0);
      tick("st_taken");
    end
    drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b1, 1'b0);
    tick("st_stalled");
    tick("st_stalled");
    drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("st_released");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd7, 4'd4, 3'b000, 1'b0, 1'b0, 1'b0);
      tick("st_not_taken");
    end
    n_total++; if (taken_cnt !== 4'd5) $display("FAIL stats_taken got=%0d exp=5", taken_cnt); else n_pass++;
    n_total++; if (not_taken_cnt !== 4'd3) $display("FAIL stats_not_taken got=%0d exp=3", not_taken_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'd7, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
      tick("sat_taken");
    end
    n_total++; if (taken_cnt !== 4'hF) $display("FAIL stats_saturate got=%0d exp=15", taken_cnt); else n_pass++;
    n_total++; if (not_taken_cnt !== TB_CNT_W'(m_ntaken))
      $display("FAIL stats_nt_model got=%0d exp=%0d", not_taken_cnt, m_ntaken); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [3:0] ic;
    int r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      ic = (r < 3) ? 4'd6 : (r < 6) ? 4'd7 : (r < 8) ? 4'd2 : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 7) != 0), ic, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      n_total++; if (e_cnd !== ref_e_cnd())
        $display("FAIL rand_cnd i=%0d got=%b exp=%b", i, e_cnd, ref_e_cnd()); else n_pass++;
      n_total++; if (e_cond_err !== ref_e_err())
        $display("FAIL rand_err i=%0d got=%b exp=%b", i, e_cond_err, ref_e_err()); else n_pass++;
      tick("rand");
      n_total++; if (cc !== m_cc) $display("FAIL rand_cc i=%0d got=%b exp=%b", i, cc, m_cc); else n_pass++;
      n_total++; if (M_cnd !== m_mcnd || M_valid !== m_mvalid)
        $display("FAIL rand_M i=%0d got=%b%b exp=%b%b", i, M_cnd, M_valid, m_mcnd, m_mvalid); else n_pass++;
`ifdef CC_COND_STATS_EN
      n_total++; if (taken_cnt !== TB_CNT_W'(m_taken) || not_taken_cnt !== TB_CNT_W'(m_ntaken))
        $display("FAIL rand_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, taken_cnt, not_taken_cnt, m_taken, m_ntaken);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_opq_flags();
    test_exc_stall();
    test_sweep();
    test_stall_bubble();
`ifdef CC_COND_STATS_EN
    test_stats();
`endif
    test_random();
`ifdef CC_COND_STATS_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
